// File: rtl/board_state_mapper.sv
// Battleship board store: command execution via valid/ready and a 2-stage pixel-to-cell-code lookup.
// Optional FOG_OF_WAR_EN: the pixel path shows un-hit ship cells (code 3) as water (code 1).
`timescale 1ns/1ps

// state   | meaning
// S_IDLE  | ready for a command
// S_EXEC  | read-modify-write of the addressed cell
// S_RESP  | one-cycle result strobe
// S_CLEAR | writing water into one cell per cycle
module board_state_mapper #(
  parameter int GRID_N    = 5,
  parameter int CELL_LOG2 = 6,
  parameter int X0        = 160,
  parameter int Y0        = 80
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clear,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic                                cmd_op,
  input  logic [2:0]                          cmd_row,
  input  logic [2:0]                          cmd_col,
  output logic                                rsp_valid,
  output logic [1:0]                          rsp_code,
  input  logic [9:0]                          pix_x,
  input  logic [9:0]                          pix_y,
  input  logic                                pix_en,
  output logic [2:0]                          state,
  output logic [$clog2(GRID_N*GRID_N+1)-1:0]  ships_left,
  output logic                                all_sunk
);

  localparam int NCELL = GRID_N * GRID_N;
  localparam int IDXW  = $clog2(NCELL);
  localparam int SLW   = $clog2(NCELL + 1);

  localparam logic [2:0] C_BLACK = 3'd0;
  localparam logic [2:0] C_WATER = 3'd1;
  localparam logic [2:0] C_WHIT  = 3'd2;
  localparam logic [2:0] C_SHIP  = 3'd3;
  localparam logic [2:0] C_SHIT  = 3'd4;

  localparam logic [1:0] RC_OK  = 2'b00;
  localparam logic [1:0] RC_HIT = 2'b01;
  localparam logic [1:0] RC_REP = 2'b10;
  localparam logic [1:0] RC_INV = 2'b11;

  localparam logic [5:0]      N6       = 6'(GRID_N);
  localparam logic [3:0]      N4       = 4'(GRID_N);
  localparam logic [9:0]      N10      = 10'(GRID_N);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCELL - 1);
  localparam logic [SLW-1:0]  SL_MAX   = SLW'(NCELL);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP, S_CLEAR} fsm_t;

  fsm_t            r_fsm;
  logic [2:0]      r_cells [NCELL];
  logic            r_cmd_ready;
  logic            r_rsp_valid;
  logic [1:0]      r_rsp_code;
  logic [SLW-1:0]  r_ships;
  logic            r_placed;
  logic            r_op;
  logic [2:0]      r_row;
  logic [2:0]      r_col;
  logic [IDXW-1:0] r_clr_idx;

  logic            w_cmd_in_range;
  logic [IDXW-1:0] w_cmd_idx;
  logic [2:0]      w_cur;

  assign w_cmd_in_range = ({1'b0, r_row} < N4) && ({1'b0, r_col} < N4);
  assign w_cmd_idx      = IDXW'({3'b000, r_row} * N6 + {3'b000, r_col});
  assign w_cur          = w_cmd_in_range ? r_cells[w_cmd_idx] : C_BLACK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_code  <= RC_OK;
      r_ships     <= '0;
      r_placed    <= 1'b0;
      r_op        <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
      r_clr_idx   <= '0;
      for (int i = 0; i < NCELL; i++) r_cells[i] <= C_WATER;
    end else if (clear) begin
      // clear wins over everything; any in-flight command is silently dropped
      r_fsm       <= S_CLEAR;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_ships     <= '0;
      r_placed    <= 1'b0;
      r_clr_idx   <= '0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          r_rsp_valid <= 1'b0;
          if (cmd_valid) begin
            r_op        <= cmd_op;
            r_row       <= cmd_row;
            r_col       <= cmd_col;
            r_cmd_ready <= 1'b0;
            r_fsm       <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_valid <= 1'b1;
          r_fsm       <= S_RESP;
          if (!w_cmd_in_range) begin
            r_rsp_code <= RC_INV;
          end else if (!r_op) begin
            if (w_cur == C_WATER) begin
              r_cells[w_cmd_idx] <= C_SHIP;
              if (r_ships != SL_MAX) r_ships <= r_ships + 1'b1;
              r_placed   <= 1'b1;
              r_rsp_code <= RC_OK;
            end else if (w_cur == C_SHIP) begin
              r_rsp_code <= RC_REP;
            end else begin
              r_rsp_code <= RC_INV;
            end
          end else begin
            if (w_cur == C_WATER) begin
              r_cells[w_cmd_idx] <= C_WHIT;
              r_rsp_code <= RC_OK;
            end else if (w_cur == C_SHIP) begin
              r_cells[w_cmd_idx] <= C_SHIT;
              if (r_ships != '0) r_ships <= r_ships - 1'b1;
              r_rsp_code <= RC_HIT;
            end else begin
              r_rsp_code <= RC_REP;
            end
          end
        end
        S_RESP: begin
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_fsm       <= S_IDLE;
        end
        S_CLEAR: begin
          r_cells[r_clr_idx] <= C_WATER;
          if (r_clr_idx == IDX_LAST) begin
            r_cmd_ready <= 1'b1;
            r_fsm       <= S_IDLE;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end
        default: begin
          r_cmd_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_fsm       <= S_IDLE;
        end
      endcase
    end
  end

  logic [10:0]     w_dx_full;
  logic [10:0]     w_dy_full;
  logic [9:0]      w_dx;
  logic [9:0]      w_dy;
  logic [9:0]      w_col_full;
  logic [9:0]      w_row_full;
  logic            w_in_grid;
  logic            w_border;
  logic [IDXW-1:0] w_pix_idx;
  logic            r_s1_show;
  logic [IDXW-1:0] r_s1_idx;
  logic [2:0]      w_cell_pix;
  logic [2:0]      r_pix_state;

  assign w_dx_full  = {1'b0, pix_x} - 11'(X0);
  assign w_dy_full  = {1'b0, pix_y} - 11'(Y0);
  assign w_dx       = w_dx_full[9:0];
  assign w_dy       = w_dy_full[9:0];
  assign w_col_full = w_dx >> CELL_LOG2;
  assign w_row_full = w_dy >> CELL_LOG2;
  assign w_in_grid  = !w_dx_full[10] && !w_dy_full[10] && (w_row_full < N10) &&
                      (w_col_full < N10) && pix_en;
  assign w_border   = (w_dx[CELL_LOG2-1:0] == '0) || (w_dy[CELL_LOG2-1:0] == '0);
  assign w_pix_idx  = IDXW'({3'b000, w_row_full[2:0]} * N6 + {3'b000, w_col_full[2:0]});

`ifdef FOG_OF_WAR_EN
  assign w_cell_pix = (r_cells[r_s1_idx] == C_SHIP) ? C_WATER : r_cells[r_s1_idx];
`else
  assign w_cell_pix = r_cells[r_s1_idx];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_show   <= 1'b0;
      r_s1_idx    <= '0;
      r_pix_state <= C_BLACK;
    end else begin
      r_s1_show   <= w_in_grid && !w_border;
      r_s1_idx    <= w_in_grid ? w_pix_idx : '0;
      r_pix_state <= r_s1_show ? w_cell_pix : C_BLACK;
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_code   = r_rsp_code;
  assign state      = r_pix_state;
  assign ships_left = r_ships;
  assign all_sunk   = r_placed && (r_ships == '0);

endmodule

// File: tb/tb_board_state_mapper.sv
// Directed bench for board_state_mapper: commands, responses, clear sequencing and pixel lookup.
`timescale 1ns/1ps

module tb_board_state_mapper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [2:0] cmd_row;
  logic [2:0] cmd_col;
  logic       rsp_valid;
  logic [1:0] rsp_code;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       pix_en;
  logic [2:0] state;
  logic [4:0] ships_left;
  logic       all_sunk;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  board_state_mapper dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_row    (cmd_row),
    .cmd_col    (cmd_col),
    .rsp_valid  (rsp_valid),
    .rsp_code   (rsp_code),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_en     (pix_en),
    .state      (state),
    .ships_left (ships_left),
    .all_sunk   (all_sunk)
  );

`ifdef FOG_OF_WAR_EN
  localparam logic [31:0] SHIP_SHOWN = 32'd1;
`else
  localparam logic [31:0] SHIP_SHOWN = 32'd3;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic en,
                     input logic [31:0] exp);
    pix_x  = 10'(x);
    pix_y  = 10'(y);
    pix_en = en;
    tick();
    tick();
    chk(tag, 32'(state), exp);
  endtask

  // Present a command in an IDLE cycle; response expected in the second cycle after that one.
  task automatic send(input string tag, input logic op, input int row, input int col,
                      input logic [1:0] exp_code);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_row   = 3'(row);
    cmd_col   = 3'(col);
    tick();
    cmd_valid = 1'b0;
    chk({tag, "_exec_novalid"}, 32'(rsp_valid), 32'd0);
    tick();
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rsp_code"}, 32'(rsp_code), 32'(exp_code));
    tick();
    chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int  cnt;
    bit  saw_rsp;

    rst_n = 1'b0; clear = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0;
    cmd_row = '0; cmd_col = '0; pix_x = '0; pix_y = '0; pix_en = 1'b0;
    #22 rst_n = 1'b1;
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_code", 32'(rsp_code), 32'd0);
    pix("rst_pix_water", 293, 149, 1'b1, 32'd1);

    // asynchronous reset in the middle of a frame
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_ships", 32'(ships_left), 32'd0);
    chk("async_rst_sunk", 32'(all_sunk), 32'd0);
    chk("async_rst_rsp", 32'(rsp_valid), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    pix("post_rst_pix", 293, 149, 1'b1, 32'd1);

    send("place_1_2", 1'b0, 1, 2, 2'b00);
    chk("ships_after_place", 32'(ships_left), 32'd1);
    chk("sunk_after_place", 32'(all_sunk), 32'd0);
    pix("pix_ship_1_2", 293, 149, 1'b1, SHIP_SHOWN);
    send("fire_1_2", 1'b1, 1, 2, 2'b01);
    chk("ships_after_hit", 32'(ships_left), 32'd0);
    chk("sunk_after_hit", 32'(all_sunk), 32'd1);
    pix("pix_hit_1_2", 293, 149, 1'b1, 32'd4);

    send("refire_1_2", 1'b1, 1, 2, 2'b10);
    send("replace_hit", 1'b0, 1, 2, 2'b11);
    send("fire_6_0", 1'b1, 6, 0, 2'b11);
    chk("ships_after_inv", 32'(ships_left), 32'd0);
    pix("pix_1_2_unchanged", 293, 149, 1'b1, 32'd4);
    pix("pix_1_0_unchanged", 165, 149, 1'b1, 32'd1);
    send("fire_0_0_water", 1'b1, 0, 0, 2'b00);
    pix("pix_water_hit", 165, 85, 1'b1, 32'd2);
    send("place_on_waterhit", 1'b0, 0, 0, 2'b11);
    send("place_3_3", 1'b0, 3, 3, 2'b00);
    send("replace_ship", 1'b0, 3, 3, 2'b10);
    chk("ships_two_cmds", 32'(ships_left), 32'd1);
    chk("sunk_not_yet", 32'(all_sunk), 32'd0);

    pix("pix_left_of_grid", 159, 100, 1'b1, 32'd0);
    pix("pix_vgridline", 224, 100, 1'b1, 32'd0);
    pix("pix_hgridline", 300, 144, 1'b1, 32'd0);
    pix("pix_corner_4_4", 479, 399, 1'b1, 32'd1);
    pix("pix_right_edge", 480, 399, 1'b1, 32'd0);
    pix("pix_below_grid", 480, 400, 1'b1, 32'd0);
    pix("pix_en_low", 293, 149, 1'b0, 32'd0);
    pix("pix_ship_3_3", 362, 282, 1'b1, SHIP_SHOWN);

    // clear arriving while a place command is in EXEC
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_row = 3'd4; cmd_col = 3'd4;
    tick();
    cmd_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_ships_zero", 32'(ships_left), 32'd0);
    chk("clr_sunk_zero", 32'(all_sunk), 32'd0);
    cnt = (cmd_ready == 1'b0) ? 1 : 0;
    saw_rsp = rsp_valid;
    for (int i = 0; i < 40 && cmd_ready == 1'b0; i++) begin
      tick();
      if (rsp_valid) saw_rsp = 1'b1;
      if (cmd_ready == 1'b0) cnt++;
    end
    chk("clr_ready_low_cycles", 32'(cnt), 32'd25);
    chk("clr_no_rsp", 32'(saw_rsp), 32'd0);
    pix("clr_cell_1_2", 293, 149, 1'b1, 32'd1);
    pix("clr_cell_0_0", 165, 85, 1'b1, 32'd1);
    pix("clr_cell_3_3", 362, 282, 1'b1, 32'd1);
    pix("clr_cell_4_4_dropped", 479, 399, 1'b1, 32'd1);

    // clear reasserted once the sweep has reached index 10
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    cnt = (cmd_ready == 1'b0) ? 1 : 0;
    for (int i = 0; i < 40 && cmd_ready == 1'b0; i++) begin
      tick();
      if (cmd_ready == 1'b0) cnt++;
    end
    chk("clr_restart_cycles", 32'(cnt), 32'd25);

    send("place_0_0", 1'b0, 0, 0, 2'b00);
    pix("pix_ship_0_0", 165, 85, 1'b1, SHIP_SHOWN);
    send("fire_0_0_ship", 1'b1, 0, 0, 2'b01);
    pix("pix_hit_0_0", 165, 85, 1'b1, 32'd4);
    chk("final_ships", 32'(ships_left), 32'd0);
    chk("final_sunk", 32'(all_sunk), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
